// File: rtl/instr_loader_mem.sv
// -----------------------------------------------------------------------------
// instr_loader_mem
// Instruction memory for the single-cycle core, filled at run time from a
// byte-serial load stream. While a program is loading, the core is held at
// its reset PC because last_pc reads 32'hFFFFFFFF. When the final byte
// arrives, last_pc is set to the index of the last loaded word, which
// releases the core.
//
// Optional build macro: INSTR_MEM_CKSUM_EN adds the ld_cksum output, a
// modulo-256 running byte sum of the current load.
//
// Ports
//   clk         system clock, all logic on posedge
//   rst         synchronous active-high reset
//   instr_addr  word address from the core (its next PC)
//   instr_data  registered instruction word, 1-cycle read latency
//   last_pc     stop bound to the core; 32'hFFFFFFFF holds the core
//   ld_start    pulse: start a new load and discard the current program
//   ld_valid    ld_data byte is valid
//   ld_data     program byte, little-endian within each word
//   ld_last     marks the final byte of the program (qualified by ld_valid)
//   ld_ready    high exactly while loading; never stalls the stream
//   ld_done     one-cycle pulse after the final byte is accepted
//   ld_ovf      sticky: words were dropped because memory was full
//   ld_cksum    (INSTR_MEM_CKSUM_EN only) running byte sum of the load
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no program loaded, core held, fetches return NOP_WORD
// LOAD  | accepting bytes, core held, fetches return NOP_WORD
// RUN   | program loaded, fetches served from memory
// -----------------------------------------------------------------------------
module instr_loader_mem #(
    parameter int          ADDR_W   = 8,
    parameter logic [31:0] NOP_WORD = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr_addr,
    output logic [31:0] instr_data,
    output logic [31:0] last_pc,
    input  logic        ld_start,
    input  logic        ld_valid,
    input  logic [7:0]  ld_data,
    input  logic        ld_last,
    output logic        ld_ready,
    output logic        ld_done,
    output logic        ld_ovf
`ifdef INSTR_MEM_CKSUM_EN
    ,
    output logic [7:0]  ld_cksum
`endif
);

    localparam int DEPTH = 2 ** ADDR_W;
    // The word count needs one extra bit so that it can saturate at DEPTH.
    localparam logic [ADDR_W:0] CNT_FULL = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [31:0]       mem [DEPTH];
    logic [ADDR_W:0]   word_cnt;
    logic [1:0]        lane;
    logic [23:0]       asm_q;       // lanes 0..2 of the word being assembled

    logic              byte_acc;
    logic              word_wr;
    logic              mem_full;
    logic              wr_en;
    logic              done_now;
    logic [31:0]       wr_word;
    logic [ADDR_W:0]   last_idx;
    logic              fetch_ok;

    // ld_start wins over a byte presented in the same cycle.
    assign byte_acc = (state == S_LOAD) && ld_valid && !ld_start;
    assign word_wr  = byte_acc && ((lane == 2'd3) || ld_last);
    assign mem_full = (word_cnt == CNT_FULL);
    assign wr_en    = word_wr && !mem_full && !rst;
    assign done_now = byte_acc && ld_last;

    // The word index after this cycle's write, minus one. Once memory is
    // full the count has already saturated, so it is not advanced.
    assign last_idx = mem_full ? (word_cnt - CNT_ONE) : word_cnt;

    assign fetch_ok = (state == S_RUN)
                   && (instr_addr[31:ADDR_W] == '0)
                   && ({1'b0, instr_addr[ADDR_W-1:0]} < word_cnt);

    // The upper lanes of a partial final word are zero-filled.
    always_comb begin
        wr_word = 32'h0;
        case (lane)
            2'd0: wr_word = {24'h0, ld_data};
            2'd1: wr_word = {16'h0, ld_data, asm_q[7:0]};
            2'd2: wr_word = {8'h0, ld_data, asm_q[15:0]};
            2'd3: wr_word = {ld_data, asm_q[23:0]};
            default: wr_word = 32'h0;
        endcase
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (ld_start) state_nxt = S_LOAD;
            S_LOAD: begin
                if (ld_start)      state_nxt = S_LOAD;
                else if (done_now) state_nxt = S_RUN;
            end
            S_RUN:  if (ld_start) state_nxt = S_LOAD;
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        ld_ready = (state == S_LOAD);
    end

    // Load datapath, stop bound and fetch port
    always_ff @(posedge clk) begin
        if (rst) begin
            word_cnt   <= '0;
            lane       <= 2'd0;
            asm_q      <= 24'h0;
            ld_ovf     <= 1'b0;
            ld_done    <= 1'b0;
            last_pc    <= 32'hFFFF_FFFF;
            instr_data <= NOP_WORD;
        end else begin
            ld_done    <= done_now;
            instr_data <= fetch_ok ? mem[instr_addr[ADDR_W-1:0]] : NOP_WORD;

            if (ld_start) begin
                word_cnt <= '0;
                lane     <= 2'd0;
                asm_q    <= 24'h0;
                ld_ovf   <= 1'b0;
                last_pc  <= 32'hFFFF_FFFF;
            end else if (byte_acc) begin
                if (word_wr) begin
                    lane  <= 2'd0;
                    asm_q <= 24'h0;
                    if (mem_full) ld_ovf   <= 1'b1;
                    else          word_cnt <= word_cnt + CNT_ONE;
                end else begin
                    lane <= lane + 2'd1;
                    case (lane)
                        2'd0:    asm_q[7:0]   <= ld_data;
                        2'd1:    asm_q[15:8]  <= ld_data;
                        default: asm_q[23:16] <= ld_data;
                    endcase
                end
                if (ld_last) begin
                    last_pc <= {{(31 - ADDR_W){1'b0}}, last_idx};
                end
            end
        end
    end

    // The array itself is not reset; after reset the word count is zero,
    // so stale contents can never be fetched.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[word_cnt[ADDR_W-1:0]] <= wr_word;
        end
    end

`ifdef INSTR_MEM_CKSUM_EN
    // Counts every accepted byte, including those dropped on overflow,
    // but not the zero-fill padding.
    always_ff @(posedge clk) begin
        if (rst || ld_start) begin
            ld_cksum <= 8'h0;
        end else if (byte_acc) begin
            ld_cksum <= ld_cksum + ld_data;
        end
    end
`endif

endmodule

// File: tb/tb_instr_loader_mem.sv
module tb_instr_loader_mem;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] instr_addr;
    logic        ld_start, ld_valid, ld_last;
    logic [7:0]  ld_data;

    logic [31:0] a_data, a_last, b_data, b_last;
    logic        a_ready, a_done, a_ovf, b_ready, b_done, b_ovf;
`ifdef INSTR_MEM_CKSUM_EN
    logic [7:0]  a_ck, b_ck;
`endif

    // a: default depth (256 words); b: ADDR_W = 2 (4 words) for overflow
    instr_loader_mem #(.ADDR_W(8)) dut_a (
        .clk(clk), .rst(rst), .instr_addr(instr_addr), .instr_data(a_data),
        .last_pc(a_last), .ld_start(ld_start), .ld_valid(ld_valid),
        .ld_data(ld_data), .ld_last(ld_last), .ld_ready(a_ready),
        .ld_done(a_done), .ld_ovf(a_ovf)
`ifdef INSTR_MEM_CKSUM_EN
        , .ld_cksum(a_ck)
`endif
    );

    instr_loader_mem #(.ADDR_W(2)) dut_b (
        .clk(clk), .rst(rst), .instr_addr(instr_addr), .instr_data(b_data),
        .last_pc(b_last), .ld_start(ld_start), .ld_valid(ld_valid),
        .ld_data(ld_data), .ld_last(ld_last), .ld_ready(b_ready),
        .ld_done(b_done), .ld_ovf(b_ovf)
`ifdef INSTR_MEM_CKSUM_EN
        , .ld_cksum(b_ck)
`endif
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_q[$];
    logic [7:0]  bq[$];
    logic [31:0] m_words[$];
    logic        m_ovf;
    logic [7:0]  m_sum;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: pack the byte list into words, zero-fill the last
    // partial word, keep at most depth words.
    task automatic build_model(input int depth);
        logic [31:0] w;
        int          ln;
        w = 32'h0;
        ln = 0;
        m_words.delete();
        m_ovf = 1'b0;
        m_sum = 8'h0;
        for (int i = 0; i < bq.size(); i++) begin
            w[8*ln +: 8] = bq[i];
            m_sum = m_sum + bq[i];
            ln++;
            if (ln == 4 || i == bq.size() - 1) begin
                if (m_words.size() < depth) m_words.push_back(w);
                else m_ovf = 1'b1;
                w = 32'h0;
                ln = 0;
            end
        end
    endtask

    task automatic pulse_start();
        ld_start = 1'b1;
        cyc();
        ld_start = 1'b0;
    endtask

    // Stream bq; ld_last on the final byte only when with_last is set.
    task automatic send_bytes(input bit use_b, input bit with_last);
        for (int i = 0; i < bq.size(); i++) begin
            chk("ld_ready_during_load", {31'h0, use_b ? b_ready : a_ready}, 32'h1);
            ld_valid = 1'b1;
            ld_data  = bq[i];
            ld_last  = with_last && (i == bq.size() - 1);
            cyc();
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic fetch(input bit use_b, input string tag, input logic [31:0] addr, input logic [31:0] exp);
        exp_q.push_back(exp);
        instr_addr = addr;
        cyc();
        chk(tag, use_b ? b_data : a_data, exp_q.pop_front());
    endtask

    // Checks after the final byte: done pulse, stop bound, then fetches.
    task automatic check_loaded(input bit use_b, input string tag);
        chk({tag, "_done"},   {31'h0, use_b ? b_done : a_done}, 32'h1);
        chk({tag, "_last_pc"}, use_b ? b_last : a_last, 32'(m_words.size() - 1));
        chk({tag, "_ready"},  {31'h0, use_b ? b_ready : a_ready}, 32'h0);
        chk({tag, "_ovf"},    {31'h0, use_b ? b_ovf : a_ovf}, {31'h0, m_ovf});
`ifdef INSTR_MEM_CKSUM_EN
        chk({tag, "_cksum"},  {24'h0, use_b ? b_ck : a_ck}, {24'h0, m_sum});
`endif
        for (int i = 0; i <= m_words.size(); i++) begin
            fetch(use_b, {tag, "_fetch"}, 32'(i), (i < m_words.size()) ? m_words[i] : NOP);
            if (i == 0) chk({tag, "_done_clr"}, {31'h0, use_b ? b_done : a_done}, 32'h0);
        end
    endtask

    initial begin
        rst = 1'b1; instr_addr = 32'h0;
        ld_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; ld_data = 8'h0;

        // reset then idle
        cyc(); cyc();
        rst = 1'b0;
        chk("rst_instr_data", a_data, NOP);
        chk("rst_last_pc", a_last, 32'hFFFF_FFFF);
        chk("rst_ready", {31'h0, a_ready}, 32'h0);
        chk("rst_done", {31'h0, a_done}, 32'h0);
        chk("rst_ovf", {31'h0, a_ovf}, 32'h0);
        fetch(0, "idle_fetch", 32'h0, NOP);

        // full-word load
        bq = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
        build_model(256);
        pulse_start();
        chk("load_last_pc_hold", a_last, 32'hFFFF_FFFF);
        send_bytes(0, 1);
        check_loaded(0, "full");
        fetch(0, "full_w1", 32'h1, 32'h00200593);
        fetch(0, "full_w0", 32'h0, 32'h00100513);

        // partial final word
        bq = '{8'hAA, 8'hBB, 8'hCC};
        build_model(256);
        pulse_start();
        send_bytes(0, 1);
        check_loaded(0, "part");
        fetch(0, "part_w0", 32'h0, 32'h00CCBBAA);
        fetch(0, "part_oor", 32'h00000100, NOP);

        // overflow on the 4-word instance
        bq.delete();
        for (int i = 0; i < 20; i++) bq.push_back(8'(i + 1));
        build_model(4);
        pulse_start();
        send_bytes(1, 1);
        check_loaded(1, "ovf");
        chk("ovf_flag", {31'h0, b_ovf}, 32'h1);
        chk("ovf_last_pc", b_last, 32'h3);

        // restart mid-load
        pulse_start();
        bq = '{8'hF1, 8'hF2, 8'hF3, 8'hF4, 8'hF5, 8'hF6};
        send_bytes(1, 0);
        pulse_start();
        bq = '{8'h01, 8'h02, 8'h03, 8'h04};
        build_model(4);
        send_bytes(1, 1);
        check_loaded(1, "restart");
        chk("restart_ovf_clr", {31'h0, b_ovf}, 32'h0);
        fetch(1, "restart_w0", 32'h0, 32'h04030201);
`ifdef INSTR_MEM_CKSUM_EN
        chk("restart_cksum", {24'h0, b_ck}, 32'h0000000A);
`endif

        // reset mid-load
        pulse_start();
        bq = '{8'h11, 8'h22, 8'h33};
        send_bytes(0, 0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("rstmid_last_pc", a_last, 32'hFFFF_FFFF);
        chk("rstmid_ready", {31'h0, a_ready}, 32'h0);
        fetch(0, "rstmid_fetch", 32'h0, NOP);

        // ld_start beats a simultaneous last byte
        pulse_start();
        ld_start = 1'b1; ld_valid = 1'b1; ld_last = 1'b1; ld_data = 8'h55;
        cyc();
        ld_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
        chk("prio_ready", {31'h0, a_ready}, 32'h1);
        chk("prio_done", {31'h0, a_done}, 32'h0);

        // ld_start in RUN
        bq = '{8'h93, 8'h00, 8'h10, 8'h00};
        build_model(256);
        send_bytes(0, 1);
        check_loaded(0, "run");
        pulse_start();
        chk("run_restart_last_pc", a_last, 32'hFFFF_FFFF);
        chk("run_restart_ready", {31'h0, a_ready}, 32'h1);
        fetch(0, "run_restart_fetch", 32'h0, NOP);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/instr_loader_mem.md
Name: instr_loader_mem

Overview:
- Instruction-memory responder for the single-cycle core: serves the core's fetch address with instruction data.
- Drives the core's last_pc stop bound.
- Filled at run time from a byte-serial load stream (host/UART side).
- Holds the core at its reset PC while a program is loading, then releases it with last_pc set to the final loaded word index.

Parameters:
ADDR_W, 8, word-address width; memory depth DEPTH = 2**ADDR_W 32-bit words
NOP_WORD, 32'h00000013, value returned for any unloaded or out-of-range fetch

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  synchronous active-high reset
instr_addr  input  32  word address from core (core's next PC)
instr_data  output  32  registered instruction word for instr_addr
last_pc  output  32  stop bound to core; 32'hFFFFFFFF holds core
ld_start  input  1  pulse: begin new load, discard current program
ld_valid  input  1  ld_data byte valid
ld_data  input  8  program byte, little-endian within each word
ld_last  input  1  qualifies the final byte of the program, sampled with ld_valid
ld_ready  output  1  loader accepts bytes (byte transfers when ld_valid & ld_ready)
ld_done  output  1  one-cycle pulse when load completes
ld_ovf  output  1  sticky: bytes were dropped because memory was full
ld_cksum  output  8  only with INSTR_MEM_CKSUM_EN: running byte sum of the loaded program

Behaviour:
- Reset values: state IDLE, instr_data = NOP_WORD, last_pc = 32'hFFFFFFFF, ld_ready = 0, ld_done = 0, ld_ovf = 0, word count = 0, byte lane = 0.
- States:
  - IDLE: no program loaded. ld_start -> LOAD.
  - LOAD: accepting bytes. Final accepted byte (ld_last) -> RUN. ld_start -> restart LOAD.
  - RUN: serving the program. ld_start -> LOAD.
  - ld_start has priority over a simultaneous byte, and is honoured in every state including mid-LOAD.
- Entering LOAD: clears word count, byte lane, assembly register and ld_ovf (and ld_cksum when enabled).
- ld_ready = 1 exactly while in LOAD. It stays high even when memory is full, so the stream never stalls.
- Byte assembly:
  - Byte lane k (0..3) goes to word bits [8k+7:8k].
  - On lane 3 the word is written at index word count, word count increments, lane wraps to 0.
- ld_last on lane < 3: the remaining upper lanes are zero-filled and the partial word is written the same cycle.
- Overflow: a word write with word count == DEPTH is discarded and sets ld_ovf. Word count saturates at DEPTH.
- Completion: on the cycle the ld_last byte is accepted:
  - the next state is RUN;
  - ld_done pulses the following cycle;
  - last_pc = word count - 1 (post-write count), registered and valid from the first RUN cycle.
- last_pc = 32'hFFFFFFFF in IDLE and LOAD, so a core at its reset PC 32'hFFFFFFFF stays put.
- Fetch: synchronous read, 1-cycle latency. instr_data at cycle n+1 = mem[instr_addr at cycle n] when all of these hold:
  - state at cycle n is RUN;
  - instr_addr[31:ADDR_W] == 0;
  - instr_addr < word count.
  Otherwise instr_data = NOP_WORD.
- Read-during-write cannot collide: reads return NOP_WORD outside RUN.
- Reset mid-LOAD: partial program discarded, back to IDLE. Memory array contents are not cleared but are unreachable, because word count = 0.

Optional Feature:
- Macro INSTR_MEM_CKSUM_EN.
- Defined: ld_cksum port exists. It is an 8-bit modulo-256 sum of every byte accepted in the current load, including dropped overflow bytes and excluding zero-fill padding. It is cleared on rst and on ld_start, and holds its value in RUN.
- Undefined: port and adder absent. All other behaviour is identical.

Test Plan:
- Reset then idle: rst for 2 cycles, instr_addr = 0 -> instr_data = 32'h00000013, last_pc = 32'hFFFFFFFF, ld_ready = 0.
- Full-word load: ld_start, then bytes 13 05 10 00 93 05 20 00 (ld_last on the 8th) -> mem[0] = 32'h00100513, mem[1] = 32'h00200593, ld_done pulse, last_pc = 1; instr_addr = 1 -> instr_data = 32'h00200593 one cycle later.
- Partial final word: bytes AA BB CC with ld_last on CC -> mem[0] = 32'h00CCBBAA, last_pc = 0; instr_addr = 1 -> NOP_WORD; instr_addr = 32'h00000100 -> NOP_WORD.
- Overflow (ADDR_W = 2): 20 bytes streamed -> 4 words stored, ld_ovf = 1, last_pc = 3, ld_ready high throughout.
- Restart mid-load: 6 bytes, ld_start, then 4 bytes 01 02 03 04 with ld_last -> last_pc = 0, mem[0] = 32'h04030201, ld_ovf = 0; with INSTR_MEM_CKSUM_EN, ld_cksum = 8'h0A.
- Reset mid-load, and ld_start in RUN -> state IDLE / LOAD respectively, last_pc returns to 32'hFFFFFFFF the next cycle, instr_data = NOP_WORD.
